// File: rtl/seq_detect_ctrl.sv
`timescale 1ns/1ps
// seq_detect_ctrl: run-time programmable serial pattern detector with match counting and
// target/timeout/abort termination. Define SEQ_CTRL_FIRST_POS_EN to capture the first-match sample index.
module seq_detect_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = $clog2(WIDTH) + 1,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             cfg_overlap,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [TO_W-1:0]  first_pos
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] target_q;
  logic             overlap_q;
  logic [TO_W-1:0]  timeout_q;

  logic [WIDTH-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [TO_W-1:0]  timer_q;

  logic [WIDTH-1:0] hist_next;
  logic [WIDTH-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic [TO_W-1:0]  timer_inc;
  logic             len_ok;
  logic             cfg_load;
  logic             start_go;
  logic             run_go;
  logic             hit;
  logic             target_hit;
  logic             expire;

  logic cfg_ready_d;
  logic cfg_err_d;
  logic busy_d;
  logic done_d;
  logic timeout_d;
  logic match_d;

  // Datapath decode shared by the FSM and the registers
  always_comb begin
    len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(WIDTH));
    cfg_load   = !abort && (state == S_IDLE) && cfg_valid && len_ok;
    start_go   = !abort && (state == S_LOADED) && start;
    run_go     = !abort && (state == S_RUN);
    hist_next  = WIDTH'({hist_q, in});
    len_mask   = ~({WIDTH{1'b1}} << len_q);
    fill_inc   = (fill_q == LEN_W'(WIDTH)) ? fill_q : fill_q + LEN_W'(1);
    hit        = in_valid && (fill_inc >= len_q) && (((hist_next ^ pat_q) & len_mask) == '0);
    cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    target_hit = hit && (target_q != '0) && (cnt_inc == target_q);
    timer_inc  = timer_q + TO_W'(1);
    expire     = (timeout_q != '0) && (timer_inc == timeout_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: abort beats target, target beats timeout
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (cfg_valid && len_ok) state_next = S_LOADED;
        S_LOADED:  if (start) state_next = S_RUN;
        S_RUN: begin
          if (target_hit) begin
            state_next = S_DONE;
          end else if (expire) begin
            state_next = S_TIMEOUT;
          end
        end
        S_DONE:    state_next = S_LOADED;
        S_TIMEOUT: state_next = S_LOADED;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it once registered
  always_comb begin
    cfg_ready_d = 1'b0;
    cfg_err_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    match_d     = 1'b0;
    cfg_ready_d = (state_next == S_IDLE);
    busy_d      = (state_next == S_RUN);
    done_d      = (state_next == S_DONE);
    timeout_d   = (state_next == S_TIMEOUT);
    cfg_err_d   = !abort && (state == S_IDLE) && cfg_valid && !len_ok;
    match_d     = run_go && hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      match     <= 1'b0;
    end else begin
      cfg_ready <= cfg_ready_d;
      cfg_err   <= cfg_err_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      match     <= match_d;
    end
  end

  // Config latch, history shifter, fill, timer and match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      target_q  <= '0;
      overlap_q <= 1'b0;
      timeout_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      timer_q   <= '0;
      match_cnt <= '0;
    end else begin
      if (cfg_load) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        target_q  <= cfg_target;
        overlap_q <= cfg_overlap;
        timeout_q <= cfg_timeout;
      end
      if (start_go) begin
        hist_q    <= '0;
        fill_q    <= '0;
        timer_q   <= '0;
        match_cnt <= '0;
      end else if (run_go) begin
        timer_q <= timer_inc;
        if (in_valid) begin
          hist_q <= hist_next;
          // Non-overlapping mode needs a full fresh pattern after each match
          fill_q <= (hit && !overlap_q) ? '0 : fill_inc;
        end
        if (hit) begin
          match_cnt <= cnt_inc;
        end
      end
    end
  end

`ifdef SEQ_CTRL_FIRST_POS_EN
  logic [TO_W-1:0] sample_idx;

  // match_cnt is still zero only until the first match of the run lands
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_idx <= '0;
      first_pos  <= '0;
    end else if (start_go) begin
      sample_idx <= '0;
      first_pos  <= '0;
    end else if (run_go && in_valid) begin
      sample_idx <= sample_idx + TO_W'(1);
      if (hit && (match_cnt == '0)) begin
        first_pos <= sample_idx;
      end
    end
  end
`else
  assign first_pos = '0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
`timescale 1ns/1ps
// Bench for seq_detect_ctrl: directed scenarios plus randomized traffic, every cycle checked
// against a queue-based reference model of the detector rules.
module tb_seq_detect_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;
`ifdef SEQ_CTRL_FIRST_POS_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             cfg_overlap = 1'b0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             cfg_err;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [TO_W-1:0]  first_pos;

  seq_detect_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_overlap(cfg_overlap),
    .cfg_timeout(cfg_timeout), .cfg_err(cfg_err),
    .start(start), .abort(abort), .in_valid(in_valid), .in(in),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done),
    .timeout(timeout), .first_pos(first_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: idle/running flags, a queue of recent samples, counters
  bit m_idle, m_running, m_match, m_done, m_timeout, m_err, m_got_first;
  int m_cnt, m_cycles, m_samples, m_first;
  logic [WIDTH-1:0] c_pat;
  int c_len, c_target, c_timeout;
  bit c_overlap;
  bit hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tail_match();
    if (hist.size() < c_len) return 1'b0;
    for (int i = 0; i < c_len; i++)
      if (hist[hist.size() - 1 - i] != c_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_running = 0; m_match = 0; m_done = 0; m_timeout = 0; m_err = 0;
    m_got_first = 0; m_cnt = 0; m_cycles = 0; m_samples = 0; m_first = 0;
    c_pat = '0; c_len = 0; c_target = 0; c_timeout = 0; c_overlap = 0;
    hist.delete();
  endtask

  task automatic model_step();
    bit was_pulse;
    was_pulse = m_done || m_timeout;
    m_match = 0; m_done = 0; m_timeout = 0; m_err = 0;
    if (abort) begin
      m_idle = 1; m_running = 0;
    end else if (m_idle) begin
      if (cfg_valid) begin
        if (int'(cfg_len) >= 1 && int'(cfg_len) <= int'(WIDTH)) begin
          c_pat = cfg_pattern; c_len = int'(cfg_len); c_target = int'(cfg_target);
          c_overlap = cfg_overlap; c_timeout = int'(cfg_timeout);
          m_idle = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_running) begin
      m_cycles++;
      if (in_valid) begin
        hist.push_back(in);
        if (hist.size() > int'(WIDTH)) void'(hist.pop_front());
        m_samples++;
        if (tail_match()) begin
          m_match = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_got_first) begin m_got_first = 1; m_first = m_samples - 1; end
          if (!c_overlap) hist.delete();
        end
      end
      if (m_match && c_target != 0 && m_cnt == c_target) begin
        m_done = 1; m_running = 0;
      end else if (c_timeout != 0 && m_cycles == c_timeout) begin
        m_timeout = 1; m_running = 0;
      end
    end else if (!was_pulse && start) begin
      m_running = 1; m_cycles = 0; m_samples = 0; m_cnt = 0; m_first = 0; m_got_first = 0;
      hist.delete();
    end
  endtask

  task automatic check_all();
    chk("cfg_ready", 32'(cfg_ready), 32'(m_idle));
    chk("busy", 32'(busy), 32'(m_running));
    chk("match", 32'(match), 32'(m_match));
    chk("done", 32'(done), 32'(m_done));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("first_pos", 32'(first_pos), FP_EN ? 32'(m_first) : 32'd0);
  endtask

  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load_cfg(input logic [WIDTH-1:0] p, input int l, input int t, input bit o,
                          input int to);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_target = CNT_W'(t);
    cfg_overlap = o; cfg_timeout = TO_W'(to);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input bit b);
    in_valid = 1'b1; in = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_a[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int s_f[4] = '{1, 1, 0, 1};
    int dcount;
    int mcount;
    int n;

    // Reset state
    rst = 1'b1; tick(); tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; tick();

    // Overlapping detection reaching target 2
    load_cfg(8'b00010010, 5, 2, 1'b1, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("a_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      feed(s_a[i][0]);
      if (i == 4) chk("a_match5", 32'(match), 32'd1);
      if (i == 7) begin
        chk("a_match8", 32'(match), 32'd1);
        chk("a_done8", 32'(done), 32'd1);
        chk("a_cnt", 32'(match_cnt), 32'd2);
      end
    end
    tick();
    chk("a_loaded_ready", 32'(cfg_ready), 32'd0);
    chk("a_loaded_busy", 32'(busy), 32'd0);
    chk("a_cnt_hold", 32'(match_cnt), 32'd2);

    // Non-overlapping: only the first match counts
    abort = 1'b1; tick(); abort = 1'b0;
    load_cfg(8'b00010010, 5, 2, 1'b0, 0);
    start = 1'b1; tick(); start = 1'b0;
    dcount = 0; mcount = 0;
    for (int i = 0; i < 8; i++) begin
      feed(s_a[i][0]);
      if (done) dcount++;
      if (match) mcount++;
    end
    chk("b_matches", 32'(mcount), 32'd1);
    chk("b_no_done", 32'(dcount), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Illegal lengths
    load_cfg(8'h00, 0, 1, 1'b1, 0);
    chk("c_err", 32'(cfg_err), 32'd1);
    chk("c_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("c_err_once", 32'(cfg_err), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("c_no_busy", 32'(busy), 32'd0);
    load_cfg(8'h00, 9, 1, 1'b1, 0);
    chk("c_err_len9", 32'(cfg_err), 32'd1);

    // Timeout with no matches
    load_cfg(8'b111, 3, 0, 1'b1, 10);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (timeout) break;
      n = 21;
    end
    in_valid = 1'b0;
    chk("d_to_cycle", 32'(n), 32'd10);
    chk("d_cnt", 32'(match_cnt), 32'd0);
    tick();

    // Mid-run abort after one match, then reset
    abort = 1'b1; tick(); abort = 1'b0;
    load_cfg(8'b01, 2, 0, 1'b1, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = c[0]; in = c[1];
      tick();
      if (match_cnt == 8'd1) break;
    end
    in_valid = 1'b0;
    chk("e_one_match", 32'(match_cnt), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("e_rst_cnt", 32'(match_cnt), 32'd0);
    chk("e_rst_match", 32'(match), 32'd0);

    // First-match position
    load_cfg(8'b01, 2, 0, 1'b1, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      feed(s_f[i][0]);
      tick();
    end
    chk("f_first_pos", 32'(first_pos), FP_EN ? 32'd3 : 32'd0);
    chk("f_cnt", 32'(match_cnt), 32'd1);

    // Randomized traffic, all outputs checked against the model every cycle
    for (int c = 0; c < 2500; c++) begin
      cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_pattern = WIDTH'($urandom);
      cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9))
                                                : LEN_W'($urandom_range(1, 3));
      cfg_target  = CNT_W'($urandom_range(0, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_timeout = ($urandom_range(0, 3) == 0) ? TO_W'(0) : TO_W'($urandom_range(3, 60));
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in          = 1'($urandom_range(0, 1));
      tick();
    end
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
